// File: rtl/sopc_bus_ic_pkg.sv
// Shared definitions for the SoPC data-side bus interconnect: FSM encoding,
// bus-error constants and the default ROM/RAM/peripheral address map.
package sopc_bus_ic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } bus_state_e;

   localparam logic [31:0] ERR_ADDR_RST = 32'h0000_0000;

   localparam int unsigned DEF_NUM_SLAVES = 4;

   // Slave 0 ROM, slave 1 RAM, slaves 2/3 peripherals; 256 MiB windows.
   localparam logic [127:0] DEF_SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                            32'h1000_0000, 32'h0000_0000};
   localparam logic [127:0] DEF_SLV_MASK = {4{32'hF000_0000}};

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/sopc_bus_ic_addr_decoder.sv
// Combinational address decoder: per-slave hit vector, lowest-index priority
// select and an any-hit flag.
module sopc_addr_decoder
   import sopc_bus_ic_pkg::*;
#(
   parameter int unsigned                    NUM_SLAVES = DEF_NUM_SLAVES,
   parameter int unsigned                    ADDR_W     = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_BASE   = DEF_SLV_BASE,
   parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_MASK   = DEF_SLV_MASK,
   localparam int unsigned                   IDX_W      = idx_width(NUM_SLAVES)
) (
   input  logic [ADDR_W-1:0]     addr_i,
   output logic [NUM_SLAVES-1:0] hit_o,
   output logic [IDX_W-1:0]      idx_o,
   output logic                  any_hit_o
);

   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_hit
      assign hit_o[g] = (addr_i & SLV_MASK[g*ADDR_W +: ADDR_W]) == SLV_BASE[g*ADDR_W +: ADDR_W];
   end

   // Scan downwards so the lowest matching index is the one left standing.
   always_comb begin
      idx_o = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (hit_o[i]) idx_o = IDX_W'(i);
      end
   end

   assign any_hit_o = |hit_o;

endmodule

// File: rtl/sopc_bus_ic.sv
// Data-side bus interconnect: latches a CPU request, drives one slave until it
// is ready (or times out), and returns read data or a one-cycle bus error.
module sopc_bus_ic
   import sopc_bus_ic_pkg::*;
#(
   parameter int unsigned                  NUM_SLAVES = DEF_NUM_SLAVES,
   parameter int unsigned                  ADDR_W     = 32,
   parameter int unsigned                  DATA_W     = 32,
   parameter int unsigned                  TIMEOUT    = 255,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = DEF_SLV_BASE,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = DEF_SLV_MASK
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         m_ce,
   input  logic                         m_we,
   input  logic [DATA_W/8-1:0]          m_sel,
   input  logic [ADDR_W-1:0]            m_addr,
   input  logic [DATA_W-1:0]            m_wdata,
   output logic [DATA_W-1:0]            m_rdata,
   output logic                         m_stall,
   output logic                         m_err,
   output logic [NUM_SLAVES-1:0]        s_ce,
   output logic                         s_we,
   output logic [DATA_W/8-1:0]          s_sel,
   output logic [ADDR_W-1:0]            s_addr,
   output logic [DATA_W-1:0]            s_wdata,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
   input  logic [NUM_SLAVES-1:0]        s_ready,
   output logic [ADDR_W-1:0]            err_addr
);

   localparam int unsigned    SEL_W   = DATA_W / 8;
   localparam int unsigned    IDX_W   = idx_width(NUM_SLAVES);
   localparam int unsigned    CNT_W   = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

   bus_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
   logic [DATA_W-1:0]      rdata_q;
   logic [ADDR_W-1:0]      err_addr_q;
   logic                   we_q;
   logic [SEL_W-1:0]       sel_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [DATA_W-1:0]      wdata_q;
   logic [IDX_W-1:0]       idx_q;
   logic [NUM_SLAVES-1:0]  sce_q;

   logic [NUM_SLAVES-1:0]  dec_hit;
   logic [IDX_W-1:0]       dec_idx;
   logic                   dec_any;
   logic                   load_req, cap_rdata, load_err, timeout_hit;

   sopc_addr_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .ADDR_W     (ADDR_W),
      .SLV_BASE   (SLV_BASE),
      .SLV_MASK   (SLV_MASK)
   ) u_dec (
      .addr_i    (m_addr),
      .hit_o     (dec_hit),
      .idx_o     (dec_idx),
      .any_hit_o (dec_any)
   );

   // Counter saturates rather than wrapping; a timeout fires on the BUSY cycle
   // that would bring it to TIMEOUT, giving exactly TIMEOUT select cycles.
   assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_CNT);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      m_stall   = 1'b0;
      m_err     = 1'b0;
      m_rdata   = '0;
      load_req  = 1'b0;
      cap_rdata = 1'b0;
      load_err  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            m_stall = m_ce & rst;
            if (m_ce) begin
               load_req = 1'b1;
               cnt_d    = '0;
               state_d  = dec_any ? ST_BUSY : ST_ERR;
            end
         end
         ST_BUSY: begin
            m_stall = 1'b1;
            cnt_d   = cnt_inc;
            if (s_ready[idx_q]) begin
               cap_rdata = ~we_q;
               state_d   = ST_DONE;
            end else if (timeout_hit) begin
               state_d = ST_ERR;
            end
         end
         ST_DONE: begin
            m_rdata = rdata_q;
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            m_err    = 1'b1;
            load_err = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rdata_q    <= '0;
         err_addr_q <= ADDR_W'(ERR_ADDR_RST);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (cap_rdata) rdata_q <= s_rdata[idx_q*DATA_W +: DATA_W];
         if (load_err)  err_addr_q <= addr_q;
      end
   end

   // Request fields are only meaningful while the FSM is past IDLE, so no reset.
   always_ff @(posedge clk) begin
      if (load_req) begin
         we_q    <= m_we;
         sel_q   <= m_sel;
         addr_q  <= m_addr;
         wdata_q <= m_wdata;
         idx_q   <= dec_idx;
         sce_q   <= dec_hit & ~(dec_hit - NUM_SLAVES'(1));
      end
   end

   assign s_ce     = (state_q == ST_BUSY) ? sce_q : '0;
   assign s_we     = we_q;
   assign s_sel    = sel_q;
   assign s_addr   = addr_q;
   assign s_wdata  = wdata_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_sopc_bus_ic.sv
// Directed self-checking bench for sopc_bus_ic with a 4-slave map where
// slaves 0 and 1 overlap at address 0.
module tb_sopc_bus_ic;

   localparam int unsigned NS = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;
   localparam logic [NS*AW-1:0] BASE = {32'h2000_0000, 32'h1000_0000,
                                        32'h0000_0000, 32'h0000_0000};
   localparam logic [NS*AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000,
                                        32'hFFFF_0000, 32'hFFFF_F000};

   logic              clk;
   logic              rst;
   logic              m_ce;
   logic              m_we;
   logic [DW/8-1:0]   m_sel;
   logic [AW-1:0]     m_addr;
   logic [DW-1:0]     m_wdata;
   logic [DW-1:0]     m_rdata;
   logic              m_stall;
   logic              m_err;
   logic [NS-1:0]     s_ce;
   logic              s_we;
   logic [DW/8-1:0]   s_sel;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_wdata;
   logic [NS*DW-1:0]  s_rdata;
   logic [NS-1:0]     s_ready;
   logic [AW-1:0]     err_addr;

   int checks   = 0;
   int failures = 0;

   sopc_bus_ic #(
      .NUM_SLAVES (NS),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .TIMEOUT    (TO),
      .SLV_BASE   (BASE),
      .SLV_MASK   (MASK)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m_ce     (m_ce),
      .m_we     (m_we),
      .m_sel    (m_sel),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_rdata  (m_rdata),
      .m_stall  (m_stall),
      .m_err    (m_err),
      .s_ce     (s_ce),
      .s_we     (s_we),
      .s_sel    (s_sel),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_rdata  (s_rdata),
      .s_ready  (s_ready),
      .err_addr (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      rst     = 1'b0;
      m_ce    = 1'b1;
      m_we    = 1'b0;
      m_sel   = 4'hF;
      m_addr  = 32'h0;
      m_wdata = 32'h0;
      s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1234_5678};
      s_ready = '0;

      tick();
      tick();
      chk("rst_stall", {31'd0, m_stall}, 32'd0);
      chk("rst_err", {31'd0, m_err}, 32'd0);
      chk("rst_sce", {28'd0, s_ce}, 32'd0);
      chk("rst_rdata", m_rdata, 32'd0);
      chk("rst_erraddr", err_addr, 32'd0);
      m_ce = 1'b0;
      rst  = 1'b1;
      tick();

      // Test 1: zero-wait read of slave 0 with ready tied high (also stale in IDLE)
      s_ready = 4'b0001;
      m_ce = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0010; m_sel = 4'hF;
      #1;
      chk("t1_stall_c1", {31'd0, m_stall}, 32'd1);
      chk("t1_sce_c1", {28'd0, s_ce}, 32'd0);
      tick();
      chk("t1_stall_c2", {31'd0, m_stall}, 32'd1);
      chk("t1_sce_c2", {28'd0, s_ce}, 32'h1);
      tick();
      chk("t1_stall_c3", {31'd0, m_stall}, 32'd0);
      chk("t1_rdata", m_rdata, 32'h1234_5678);
      chk("t1_err", {31'd0, m_err}, 32'd0);
      m_ce = 1'b0;
      tick();
      chk("t1_no_reaccept", {28'd0, s_ce}, 32'd0);
      chk("t1_idle_stall", {31'd0, m_stall}, 32'd0);
      s_ready = '0;

      // Test 2: write slave 2, three wait states, request inputs scrambled after acceptance
      m_ce = 1'b1; m_we = 1'b1; m_addr = 32'h1000_0004; m_sel = 4'b0011; m_wdata = 32'hA5A5_5A5A;
      #1;
      chk("t2_stall_idle", {31'd0, m_stall}, 32'd1);
      tick();
      m_ce = 1'b0; m_we = 1'b0; m_addr = 32'hFFFF_FFFF; m_sel = 4'hC; m_wdata = 32'h0;
      for (int k = 0; k < 4; k++) begin
         s_ready = (k == 3) ? 4'b0100 : 4'b0000;
         #1;
         chk($sformatf("t2_sce_%0d", k), {28'd0, s_ce}, 32'h4);
         chk($sformatf("t2_stall_%0d", k), {31'd0, m_stall}, 32'd1);
         chk($sformatf("t2_wdata_%0d", k), s_wdata, 32'hA5A5_5A5A);
         chk($sformatf("t2_sel_%0d", k), {28'd0, s_sel}, 32'h3);
         chk($sformatf("t2_addr_%0d", k), s_addr, 32'h1000_0004);
         chk($sformatf("t2_we_%0d", k), {31'd0, s_we}, 32'd1);
         tick();
      end
      s_ready = '0;
      chk("t2_done_stall", {31'd0, m_stall}, 32'd0);
      chk("t2_done_sce", {28'd0, s_ce}, 32'd0);
      chk("t2_done_rdata", m_rdata, 32'h1234_5678);
      tick();

      // Test 3: unmapped address
      m_ce = 1'b1; m_we = 1'b0; m_addr = 32'hDEAD_0000; m_sel = 4'hF;
      #1;
      chk("t3_stall_idle", {31'd0, m_stall}, 32'd1);
      tick();
      m_ce = 1'b0;
      #1;
      chk("t3_err", {31'd0, m_err}, 32'd1);
      chk("t3_rdata", m_rdata, 32'd0);
      chk("t3_sce", {28'd0, s_ce}, 32'd0);
      chk("t3_stall", {31'd0, m_stall}, 32'd0);
      tick();
      chk("t3_err_pulse", {31'd0, m_err}, 32'd0);
      chk("t3_erraddr", err_addr, 32'hDEAD_0000);

      // Test 4: slave 1 never ready, timeout after 8 select cycles
      m_ce = 1'b1; m_we = 1'b0; m_addr = 32'h0000_2000;
      #1;
      tick();
      m_ce = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("t4_sce_%0d", k), {28'd0, s_ce}, 32'h2);
         chk($sformatf("t4_err_%0d", k), {31'd0, m_err}, 32'd0);
         tick();
      end
      chk("t4_err", {31'd0, m_err}, 32'd1);
      chk("t4_sce_off", {28'd0, s_ce}, 32'd0);
      chk("t4_rdata", m_rdata, 32'd0);
      tick();
      chk("t4_idle_err", {31'd0, m_err}, 32'd0);
      chk("t4_idle_stall", {31'd0, m_stall}, 32'd0);
      chk("t4_erraddr", err_addr, 32'h0000_2000);

      // Test 5: reset during BUSY, then a normal read of slave 3
      m_ce = 1'b1; m_we = 1'b0; m_addr = 32'h2000_0008;
      #1;
      tick();
      m_ce = 1'b0;
      #1;
      chk("t5_busy_sce", {28'd0, s_ce}, 32'h8);
      tick();
      rst = 1'b0;
      tick();
      chk("t5_rst_sce", {28'd0, s_ce}, 32'd0);
      chk("t5_rst_stall", {31'd0, m_stall}, 32'd0);
      chk("t5_rst_err", {31'd0, m_err}, 32'd0);
      chk("t5_rst_erraddr", err_addr, 32'd0);
      rst = 1'b1;
      tick();
      s_ready = 4'b1000;
      m_ce = 1'b1; m_addr = 32'h2000_0008;
      #1;
      chk("t5_stall_c1", {31'd0, m_stall}, 32'd1);
      tick();
      chk("t5_sce_c2", {28'd0, s_ce}, 32'h8);
      tick();
      chk("t5_stall_c3", {31'd0, m_stall}, 32'd0);
      chk("t5_rdata", m_rdata, 32'h3333_3333);
      m_ce = 1'b0;
      s_ready = '0;
      tick();

      // Test 6: overlapping windows at 0x0, slave 1 ready must be ignored
      s_ready = 4'b0010;
      m_ce = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0000;
      #1;
      tick();
      m_ce = 1'b0;
      #1;
      chk("t6_sce_c2", {28'd0, s_ce}, 32'h1);
      tick();
      chk("t6_sce_c3", {28'd0, s_ce}, 32'h1);
      chk("t6_stall_c3", {31'd0, m_stall}, 32'd1);
      s_ready = 4'b0011;
      tick();
      chk("t6_done_stall", {31'd0, m_stall}, 32'd0);
      chk("t6_rdata", m_rdata, 32'h1234_5678);
      s_ready = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
